// File: rtl/flexbex_ibex_alu_pkg.sv
// flexbex_ibex_alu_pkg: operator codes, FSM states and shifter modes for the multi-cycle ALU
package flexbex_ibex_alu_pkg;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SRA, ALU_SRL, ALU_SLL,
    ALU_LT, ALU_LTU, ALU_LE, ALU_LEU, ALU_GT, ALU_GTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE,
    ALU_SLT, ALU_SLTU, ALU_SLET, ALU_SLETU,
    ALU_ROR, ALU_ROL, ALU_CLZ, ALU_CTZ, ALU_PCNT
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_VALID = 2'd2} alu_state_e;
  typedef enum logic [2:0] {SH_SRA, SH_SRL, SH_SLL, SH_ROR, SH_ROL} shift_mode_e;
  function automatic logic is_shift(input logic [4:0] op);
    return op inside {ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROR, ALU_ROL};
  endfunction
  function automatic shift_mode_e shift_mode(input logic [4:0] op);
    return op == ALU_SRA ? SH_SRA : op == ALU_SRL ? SH_SRL : op == ALU_ROR ? SH_ROR :
           op == ALU_ROL ? SH_ROL : SH_SLL;
  endfunction
endpackage

// File: rtl/flexbex_ibex_alu_shift_step.sv
// flexbex_ibex_alu_shift_step: one combinational shift/rotate step of the working register
module flexbex_ibex_alu_shift_step
  import flexbex_ibex_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  shift_mode_e      mode_i,
  output logic [WIDTH-1:0] data_o
);
  logic [2*WIDTH-1:0] dbl_r, dbl_l;
  logic [WIDTH-1:0]   sra;
  always_comb begin
    sra    = $signed(data_i) >>> amt_i;
    dbl_r  = {data_i, data_i} >> amt_i;
    dbl_l  = {data_i, data_i} << amt_i;
    data_o = mode_i == SH_SRA ? sra :
             mode_i == SH_SRL ? data_i >> amt_i :
             mode_i == SH_SLL ? data_i << amt_i :
             mode_i == SH_ROR ? dbl_r[WIDTH-1:0] :
             mode_i == SH_ROL ? dbl_l[2*WIDTH-1:WIDTH] : data_i;
  end
endmodule

// File: rtl/flexbex_ibex_alu_mc.sv
// flexbex_ibex_alu_mc: handshaked multi-cycle ALU with iterative shifter and registered results
module flexbex_ibex_alu_mc
  import flexbex_ibex_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cmp_result_o,
  output logic             is_equal_o
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int AMT_W   = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP = AMT_W'(SHIFT_STEP);

  alu_state_e         state_q, state_d;
  shift_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d, result_q, result_d, alu_res, shifted;
  logic [SHAMT_W-1:0] rem_q, rem_d, shamt;
  logic [AMT_W-1:0]   step, clz, ctz, pcnt;
  logic [WIDTH:0]     adder_out;
  logic               cmp_q, cmp_d, eq_q, eq_d, eq_pend_q, eq_pend_d;
  logic               sub, signed_cmp, eq, lt, cmp, accept;

  assign shamt   = operand_b_i[SHAMT_W-1:0];
  assign ready_o = state_q == ST_IDLE || (state_q == ST_VALID && ready_i);
  assign accept  = valid_i && ready_o && !flush_i;
  assign step    = {1'b0, rem_q} > STEP ? STEP : {1'b0, rem_q};

  always_comb begin
    sub        = operator_i != ALU_ADD;
    adder_out  = {operand_a_i, 1'b1} + (sub ? {~operand_b_i, 1'b1} : {operand_b_i, 1'b0});
    eq         = operand_a_i == operand_b_i;
    signed_cmp = operator_i inside {ALU_LT, ALU_LE, ALU_GT, ALU_GE, ALU_SLT, ALU_SLET};
    // differing signs decide the order directly; otherwise the difference sign does
    lt = operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1] ?
         (signed_cmp ? operand_a_i[WIDTH-1] : operand_b_i[WIDTH-1]) : adder_out[WIDTH];
    case (operator_i)
      ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU:     cmp = lt;
      ALU_LE, ALU_LEU, ALU_SLET, ALU_SLETU:   cmp = lt | eq;
      ALU_GT, ALU_GTU:                        cmp = !(lt | eq);
      ALU_GE, ALU_GEU:                        cmp = !lt;
      ALU_EQ:                                 cmp = eq;
      ALU_NE:                                 cmp = !eq;
      default:                                cmp = 1'b0;
    endcase
    clz  = AMT_W'(WIDTH);
    ctz  = AMT_W'(WIDTH);
    pcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (operand_a_i[i]) clz = AMT_W'(WIDTH - 1 - i);
      if (operand_a_i[WIDTH-1-i]) ctz = AMT_W'(WIDTH - 1 - i);
      pcnt = pcnt + AMT_W'(operand_a_i[i]);
    end
    case (operator_i)
      ALU_ADD, ALU_SUB:                                 alu_res = adder_out[WIDTH:1];
      ALU_XOR:                                          alu_res = operand_a_i ^ operand_b_i;
      ALU_OR:                                           alu_res = operand_a_i | operand_b_i;
      ALU_AND:                                          alu_res = operand_a_i & operand_b_i;
      ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROR, ALU_ROL:       alu_res = operand_a_i;
      ALU_LT, ALU_LTU, ALU_LE, ALU_LEU, ALU_GT, ALU_GTU,
      ALU_GE, ALU_GEU, ALU_EQ, ALU_NE, ALU_SLT, ALU_SLTU,
      ALU_SLET, ALU_SLETU:                              alu_res = WIDTH'(cmp);
      ALU_CLZ:                                          alu_res = WIDTH'(clz);
      ALU_CTZ:                                          alu_res = WIDTH'(ctz);
      ALU_PCNT:                                         alu_res = WIDTH'(pcnt);
      default:                                          alu_res = '0;
    endcase
  end

  flexbex_ibex_alu_shift_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .data_i(work_q),
    .amt_i (step),
    .mode_i(mode_q),
    .data_o(shifted)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    work_d    = work_q;
    rem_d     = rem_q;
    result_d  = result_q;
    cmp_d     = cmp_q;
    eq_d      = eq_q;
    eq_pend_d = eq_pend_q;
    if (flush_i) state_d = ST_IDLE;
    else if (accept) begin
      eq_pend_d = eq;
      mode_d    = shift_mode(operator_i);
      work_d    = operand_a_i;
      rem_d     = shamt;
      if (is_shift(operator_i) && shamt != '0) state_d = ST_BUSY;
      else begin
        state_d  = ST_VALID;
        result_d = alu_res;
        cmp_d    = cmp;
        eq_d     = eq;
      end
    end else if (state_q == ST_BUSY) begin
      work_d = shifted;
      rem_d  = rem_q - step[SHAMT_W-1:0];
      if (rem_d == '0) begin
        state_d  = ST_VALID;
        result_d = shifted;
        cmp_d    = 1'b0;
        eq_d     = eq_pend_q;
      end
    end else if (state_q == ST_VALID && ready_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mode_q    <= SH_SRA;
      work_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cmp_q     <= 1'b0;
      eq_q      <= 1'b0;
      eq_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      cmp_q     <= cmp_d;
      eq_q      <= eq_d;
      eq_pend_q <= eq_pend_d;
    end
  end

  assign valid_o      = state_q == ST_VALID;
  assign result_o     = result_q;
  assign cmp_result_o = cmp_q;
  assign is_equal_o   = eq_q;
endmodule

// File: tb/tb_flexbex_ibex_alu_mc.sv
// tb_flexbex_ibex_alu_mc: directed vectors with a queue scoreboard and a decoupled monitor
module tb_flexbex_ibex_alu_mc;
  import flexbex_ibex_alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        cmp;
    logic        eq;
    bit          chk_cmp;
    int          obs;
  } exp_t;

  logic        clk = 1'b0, rst_ni = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [4:0]  operator_i = '0;
  logic [31:0] operand_a_i = '0, operand_b_i = '0;
  logic        ready_o, valid_o, cmp_result_o, is_equal_o;
  logic [31:0] result_o;
  int          cyc = 0, n_cmp = 0, n_err = 0;
  exp_t        q[$];

  flexbex_ibex_alu_mc #(.WIDTH(32), .SHIFT_STEP(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .cmp_result_o(cmp_result_o), .is_equal_o(is_equal_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // lat is the cycle at which valid_o is due after the accepting edge (-1: not timed)
  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a, b, res,
                       input logic cmp, eq, input bit chk_cmp, input int lat, input bit push);
    exp_t e;
    int   w = 0;
    valid_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b;
    do begin
      @(negedge clk);
      w++;
    end while (!ready_o && w < 40);
    if (!ready_o) begin
      chk({name, " accept timeout"}, 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    e = '{name, res, cmp, eq, chk_cmp, lat < 0 ? -1 : cyc + lat - 1};
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && valid_o && ready_i) begin
      if (q.size() == 0) chk("unexpected result valid_o", 32'(valid_o), 32'd0);
      else begin
        e = q.pop_front();
        chk({e.name, " result"}, result_o, e.res);
        chk({e.name, " is_equal"}, 32'(is_equal_o), 32'(e.eq));
        if (e.chk_cmp) chk({e.name, " cmp"}, 32'(cmp_result_o), 32'(e.cmp));
        if (e.obs >= 0) chk({e.name, " latency cycle"}, cyc, e.obs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #3 rst_ni = 1'b0;
    #1;
    chk("reset valid_o", 32'(valid_o), 0);
    chk("reset ready_o", 32'(ready_o), 1);
    chk("reset result_o", result_o, 0);
    chk("reset cmp", 32'(cmp_result_o), 0);
    chk("reset is_equal", 32'(is_equal_o), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    issue("ADD ovf",   ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 0, 1, 1);
    issue("SUB wrap",  ALU_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 0, 0, 0, 1, 1);
    issue("SRA 31",    ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 0, 0, 5, 1);
    issue("SLL 0",     ALU_SLL,  32'h1,        32'd0,        32'h1,        0, 0, 0, 1, 1);
    issue("SRL 4",     ALU_SRL,  32'hF0000000, 32'd4,        32'h0F000000, 0, 0, 0, 2, 1);
    issue("ROR 8",     ALU_ROR,  32'h12345678, 32'd8,        32'h78123456, 0, 0, 0, 2, 1);
    issue("ROL 12",    ALU_ROL,  32'h12345678, 32'd12,       32'h45678123, 0, 0, 0, 3, 1);
    issue("ROR eq",    ALU_ROR,  32'h8,        32'h8,        32'h08000000, 0, 1, 0, 2, 1);
    issue("SLTU",      ALU_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1,        1, 0, 1, 1, 1);
    issue("SLT",       ALU_SLT,  32'h1,        32'hFFFFFFFF, 32'h0,        0, 0, 1, 1, 1);
    issue("EQ",        ALU_EQ,   32'h5,        32'h5,        32'h1,        1, 1, 1, 1, 1);
    issue("NE",        ALU_NE,   32'h3,        32'h4,        32'h1,        1, 0, 1, 1, 1);
    issue("GE signed", ALU_GE,   32'hFFFFFFFF, 32'h1,        32'h0,        0, 0, 1, 1, 1);
    issue("GTU",       ALU_GTU,  32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, 1, 1, 1);
    issue("LEU eq",    ALU_LEU,  32'h7,        32'h7,        32'h1,        1, 1, 1, 1, 1);
    issue("CLZ 0",     ALU_CLZ,  32'h0,        32'h0,        32'd32,       0, 1, 0, 1, 1);
    issue("CTZ 80",    ALU_CTZ,  32'h80,       32'h0,        32'd7,        0, 0, 0, 1, 1);
    issue("PCNT",      ALU_PCNT, 32'h0000F0F0, 32'h0,        32'd8,        0, 0, 0, 1, 1);
    issue("XOR eq",    ALU_XOR,  32'h1234,     32'h1234,     32'h0,        0, 1, 0, 1, 1);
    issue("bad op",    5'd31,    32'h1,        32'h2,        32'h0,        0, 0, 1, 1, 1);
    drain();
    ready_i = 1'b0;
    issue("XOR held",  ALU_XOR,  32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 0, 0, 0, -1, 1);
    operand_a_i = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("backpressure valid_o", 32'(valid_o), 1);
      chk("backpressure ready_o", 32'(ready_o), 0);
      chk("backpressure result_o", result_o, 32'hAAAAAAAA);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    issue("ADD release", ALU_ADD, 32'h2, 32'h3, 32'h5, 0, 0, 0, 1, 1);
    drain();
    ready_i = 1'b0;
    issue("SUB held",  ALU_SUB,  32'd10, 32'd3, 32'd7, 0, 0, 0, -1, 1);
    flush_i = 1'b1; valid_i = 1'b1; operator_i = ALU_ADD; ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("flush VALID valid_o", 32'(valid_o), 0);
    chk("flush VALID ready_o", 32'(ready_o), 1);
    chk("flush VALID result kept", result_o, 32'd7);
    @(posedge clk);
    #1;
    issue("SLL 24 flushed", ALU_SLL, 32'h1, 32'd24, 32'h0, 0, 0, 0, -1, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b1; valid_i = 1'b1; operator_i = ALU_ADD;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("flush BUSY valid_o", 32'(valid_o), 0);
    chk("flush BUSY ready_o", 32'(ready_o), 1);
    chk("flush BUSY result kept", result_o, 32'd7);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    issue("SRA reset", ALU_SRA, 32'h80000000, 32'd31, 32'h0, 0, 0, 0, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid-BUSY reset valid_o", 32'(valid_o), 0);
    chk("mid-BUSY reset ready_o", 32'(ready_o), 1);
    chk("mid-BUSY reset result_o", result_o, 0);
    chk("mid-BUSY reset cmp", 32'(cmp_result_o), 0);
    chk("mid-BUSY reset is_equal", 32'(is_equal_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    issue("OR after reset", ALU_OR, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0, 1, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
